rename_stage: RTL and testbench

- Consumer end of the decode3-to-rename interface. Takes one decoded instruction per cycle and renames its architectural operands.
- Sources rs1/rs2/rs3 are mapped through a speculative RAT. A new physical register is allocated for rd from a bit-vector free list.
- Result is registered toward dispatch. Retirement updates an architectural RAT and frees the old mapping. Flush rebuilds speculative state from the architectural state.

---
 rtl/rename_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_rename_stage.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_stage.sv
// rename_stage: maps rs1/rs2/rs3 through a speculative RAT and allocates a new
// physical register for rd from a bit-vector free list. The result goes to
// dispatch through a one-deep output register. Retirement updates the
// architectural RAT and frees the old mapping. A flush rebuilds the speculative
// RAT and the free list from the architectural RAT, including a same-cycle commit.
// Optional feature: define RENAME_PERF_CNT_EN to add the saturating
// perf_freelist_stall counter output.
module rename_stage #(
  parameter int NUM_PREGS = 64,
  parameter int XLEN      = 32,
  parameter int META_W    = 16,
  localparam int PW       = $clog2(NUM_PREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              flush_valid,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [META_W-1:0] in_meta,
  input  logic              in_rs1_valid,
  input  logic              in_rs1_predetermined,
  input  logic [4:0]        in_rs1_sel,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic              in_rs2_valid,
  input  logic              in_rs2_predetermined,
  input  logic [4:0]        in_rs2_sel,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic              in_rs3_valid,
  input  logic              in_rs3_predetermined,
  input  logic [4:0]        in_rs3_sel,
  input  logic [XLEN-1:0]   in_rs3_val,
  input  logic              in_rd_valid,
  input  logic [4:0]        in_rd_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [META_W-1:0] out_meta,
  output logic              out_rs1_valid,
  output logic              out_rs1_predetermined,
  output logic [PW-1:0]     out_rs1_preg,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic              out_rs2_valid,
  output logic              out_rs2_predetermined,
  output logic [PW-1:0]     out_rs2_preg,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic              out_rs3_valid,
  output logic              out_rs3_predetermined,
  output logic [PW-1:0]     out_rs3_preg,
  output logic [XLEN-1:0]   out_rs3_val,
  output logic              out_rd_valid,
  output logic [PW-1:0]     out_prd,
  output logic [PW-1:0]     out_old_prd,
  input  logic              commit_valid,
  input  logic [4:0]        commit_arch_rd,
  input  logic [PW-1:0]     commit_prd,
  input  logic [PW-1:0]     commit_old_prd,
`ifdef RENAME_PERF_CNT_EN
  output logic [31:0]       perf_freelist_stall,
`endif
  output logic [PW:0]       free_count
);

  localparam int NUM_AREGS = 32;
  localparam logic [PW:0] FREE_AT_RST = NUM_PREGS[PW:0] - NUM_AREGS[PW:0];

  // Lowest-index set bit; preg 0 is never free, so 0 doubles as "none".
  function automatic logic [PW-1:0] lowest_set(input logic [NUM_PREGS-1:0] v);
    logic [PW-1:0] idx;
    idx = '0;
    for (int p = NUM_PREGS - 1; p >= 0; p--) begin
      idx = v[p] ? PW'(p) : idx;
    end
    return idx;
  endfunction

  // Population count of the free vector.
  function automatic logic [PW:0] popcount(input logic [NUM_PREGS-1:0] v);
    logic [PW:0] cnt;
    cnt = '0;
    for (int p = 0; p < NUM_PREGS; p++) begin
      cnt = cnt + {{PW{1'b0}}, v[p]};
    end
    return cnt;
  endfunction

  logic [PW-1:0]        spec_rat_q [NUM_AREGS];
  logic [PW-1:0]        spec_rat_d [NUM_AREGS];
  logic [PW-1:0]        arch_rat_q [NUM_AREGS];
  logic [PW-1:0]        arch_rat_d [NUM_AREGS];
  logic [NUM_PREGS-1:0] free_q;
  logic [NUM_PREGS-1:0] free_d;
  logic [NUM_PREGS-1:0] arch_ref_s;
  logic [PW:0]          free_count_q;

  logic          rd_needed_s;
  logic          adv_s;
  logic          free_any_s;
  logic          in_ready_s;
  logic          accept_s;
  logic [PW-1:0] prd_s;
  logic [PW-1:0] old_prd_s;
  logic [PW-1:0] rs1_preg_s;
  logic [PW-1:0] rs2_preg_s;
  logic [PW-1:0] rs3_preg_s;

  // x0 is hard-wired, so it never gets a new mapping.
  assign rd_needed_s = in_rd_valid && (in_rd_sel != 5'd0);
  assign adv_s       = !out_valid || out_ready;
  assign free_any_s  = |free_q;
  assign in_ready_s  = adv_s && !flush_valid && (!rd_needed_s || free_any_s);
  assign accept_s    = in_valid && in_ready_s && clk_en;
  assign in_ready    = in_ready_s;
  assign free_count  = free_count_q;

  // Lookups use the RAT as it stands before this instruction's rd update.
  assign prd_s      = lowest_set(free_q);
  assign old_prd_s  = spec_rat_q[in_rd_sel];
  assign rs1_preg_s = (in_rs1_valid && !in_rs1_predetermined) ? spec_rat_q[in_rs1_sel] : '0;
  assign rs2_preg_s = (in_rs2_valid && !in_rs2_predetermined) ? spec_rat_q[in_rs2_sel] : '0;
  assign rs3_preg_s = (in_rs3_valid && !in_rs3_predetermined) ? spec_rat_q[in_rs3_sel] : '0;

  // Next RAT/free-list state: commit first, then either flush rebuild or allocation.
  always_comb begin
    arch_rat_d = arch_rat_q;
    spec_rat_d = spec_rat_q;
    free_d     = free_q;
    arch_ref_s = '0;
    if (commit_valid && (commit_arch_rd != 5'd0)) begin
      arch_rat_d[commit_arch_rd] = commit_prd;
    end else begin
      arch_rat_d = arch_rat_q;
    end
    // A freed register only becomes visible to lowest_set on the next cycle.
    if (commit_valid && (commit_old_prd != {PW{1'b0}})) begin
      free_d[commit_old_prd] = 1'b1;
    end else begin
      free_d = free_q;
    end
    for (int i = 0; i < NUM_AREGS; i++) begin
      arch_ref_s[arch_rat_d[i]] = 1'b1;
    end
    if (flush_valid) begin
      spec_rat_d = arch_rat_d;
      free_d     = ~arch_ref_s;
      free_d[0]  = 1'b0;
    end else if (accept_s && rd_needed_s) begin
      spec_rat_d[in_rd_sel] = prd_s;
      free_d[prd_s]         = 1'b0;
    end else begin
      spec_rat_d = spec_rat_q;
    end
  end

  // Rename state: both RATs, free list and its registered population count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        spec_rat_q[i] <= PW'(i);
        arch_rat_q[i] <= PW'(i);
      end
      free_q       <= {{(NUM_PREGS - NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};
      free_count_q <= FREE_AT_RST;
    end else if (clk_en) begin
      spec_rat_q   <= spec_rat_d;
      arch_rat_q   <= arch_rat_d;
      free_q       <= free_d;
      free_count_q <= popcount(free_d);
    end
  end

  // Output register toward dispatch: flush drops, accept loads, stall holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid             <= 1'b0;
      out_pc                <= '0;
      out_meta              <= '0;
      out_rs1_valid         <= 1'b0;
      out_rs1_predetermined <= 1'b0;
      out_rs1_preg          <= '0;
      out_rs1_val           <= '0;
      out_rs2_valid         <= 1'b0;
      out_rs2_predetermined <= 1'b0;
      out_rs2_preg          <= '0;
      out_rs2_val           <= '0;
      out_rs3_valid         <= 1'b0;
      out_rs3_predetermined <= 1'b0;
      out_rs3_preg          <= '0;
      out_rs3_val           <= '0;
      out_rd_valid          <= 1'b0;
      out_prd               <= '0;
      out_old_prd           <= '0;
    end else if (clk_en) begin
      if (flush_valid) begin
        out_valid <= 1'b0;
      end else if (accept_s) begin
        out_valid             <= 1'b1;
        out_pc                <= in_pc;
        out_meta              <= in_meta;
        out_rs1_valid         <= in_rs1_valid;
        out_rs1_predetermined <= in_rs1_predetermined;
        out_rs1_preg          <= rs1_preg_s;
        out_rs1_val           <= in_rs1_val;
        out_rs2_valid         <= in_rs2_valid;
        out_rs2_predetermined <= in_rs2_predetermined;
        out_rs2_preg          <= rs2_preg_s;
        out_rs2_val           <= in_rs2_val;
        out_rs3_valid         <= in_rs3_valid;
        out_rs3_predetermined <= in_rs3_predetermined;
        out_rs3_preg          <= rs3_preg_s;
        out_rs3_val           <= in_rs3_val;
        out_rd_valid          <= rd_needed_s;
        out_prd               <= rd_needed_s ? prd_s : '0;
        out_old_prd           <= rd_needed_s ? old_prd_s : '0;
      end else if (adv_s) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

`ifdef RENAME_PERF_CNT_EN
  // Saturating count of cycles an rd-writing instruction waits on an empty free list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_freelist_stall <= 32'd0;
    end else if (clk_en && in_valid && adv_s && rd_needed_s && !free_any_s
                 && (perf_freelist_stall != 32'hFFFF_FFFF)) begin
      perf_freelist_stall <= perf_freelist_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage: a reference model of the RATs and
// free list pushes expected outputs into a queue on accept; they are popped
// and compared when dispatch takes the output.
module tb_rename_stage;

  logic        clk = 1'b0;
  logic        rst, clk_en, flush_valid, in_valid, in_ready;
  logic [31:0] in_pc;
  logic [15:0] in_meta;
  logic        in_rs1_valid, in_rs1_predetermined, in_rs2_valid, in_rs2_predetermined;
  logic        in_rs3_valid, in_rs3_predetermined, in_rd_valid;
  logic [4:0]  in_rs1_sel, in_rs2_sel, in_rs3_sel, in_rd_sel;
  logic [31:0] in_rs1_val, in_rs2_val, in_rs3_val;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [15:0] out_meta;
  logic        out_rs1_valid, out_rs1_predetermined, out_rs2_valid, out_rs2_predetermined;
  logic        out_rs3_valid, out_rs3_predetermined, out_rd_valid;
  logic [5:0]  out_rs1_preg, out_rs2_preg, out_rs3_preg, out_prd, out_old_prd;
  logic [31:0] out_rs1_val, out_rs2_val, out_rs3_val;
  logic        commit_valid;
  logic [4:0]  commit_arch_rd;
  logic [5:0]  commit_prd, commit_old_prd;
  logic [6:0]  free_count;
`ifdef RENAME_PERF_CNT_EN
  logic [31:0] perf_freelist_stall;
  logic [31:0] m_perf;
  logic [31:0] perf0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] meta;
    logic [2:0]  v;
    logic [2:0]  p;
    logic [5:0]  p1, p2, p3;
    logic [31:0] v1, v2, v3;
    logic        rdv;
    logic [5:0]  prd, old;
  } exp_t;

  exp_t        sb[$];
  logic [5:0]  m_spec [32];
  logic [5:0]  m_arch [32];
  logic [63:0] m_free;
  logic        m_ov;
  logic [31:0] pc_next;
  logic [31:0] t3_pc;
  int          n_tests = 0;
  int          n_fail  = 0;

  rename_stage dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush_valid(flush_valid),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_meta(in_meta),
    .in_rs1_valid(in_rs1_valid), .in_rs1_predetermined(in_rs1_predetermined),
    .in_rs1_sel(in_rs1_sel), .in_rs1_val(in_rs1_val),
    .in_rs2_valid(in_rs2_valid), .in_rs2_predetermined(in_rs2_predetermined),
    .in_rs2_sel(in_rs2_sel), .in_rs2_val(in_rs2_val),
    .in_rs3_valid(in_rs3_valid), .in_rs3_predetermined(in_rs3_predetermined),
    .in_rs3_sel(in_rs3_sel), .in_rs3_val(in_rs3_val),
    .in_rd_valid(in_rd_valid), .in_rd_sel(in_rd_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_meta(out_meta),
    .out_rs1_valid(out_rs1_valid), .out_rs1_predetermined(out_rs1_predetermined),
    .out_rs1_preg(out_rs1_preg), .out_rs1_val(out_rs1_val),
    .out_rs2_valid(out_rs2_valid), .out_rs2_predetermined(out_rs2_predetermined),
    .out_rs2_preg(out_rs2_preg), .out_rs2_val(out_rs2_val),
    .out_rs3_valid(out_rs3_valid), .out_rs3_predetermined(out_rs3_predetermined),
    .out_rs3_preg(out_rs3_preg), .out_rs3_val(out_rs3_val),
    .out_rd_valid(out_rd_valid), .out_prd(out_prd), .out_old_prd(out_old_prd),
    .commit_valid(commit_valid), .commit_arch_rd(commit_arch_rd),
    .commit_prd(commit_prd), .commit_old_prd(commit_old_prd),
`ifdef RENAME_PERF_CNT_EN
    .perf_freelist_stall(perf_freelist_stall),
`endif
    .free_count(free_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) begin
      m_spec[i] = 6'(i);
      m_arch[i] = 6'(i);
    end
    m_free = {32'hFFFF_FFFF, 32'h0000_0000};
    m_ov   = 1'b0;
    sb.delete();
`ifdef RENAME_PERF_CNT_EN
    m_perf = 32'd0;
`endif
  endtask

  task automatic set_instr(input logic v, input logic rdv, input logic [4:0] rd,
                           input logic [4:0] s1, input logic s1p, input logic [31:0] s1v,
                           input logic [4:0] s2);
    in_valid             = v;
    in_pc                = pc_next;
    pc_next              = pc_next + 32'd4;
    in_meta              = 16'($urandom);
    in_rd_valid          = rdv;
    in_rd_sel            = rd;
    in_rs1_valid         = 1'b1;
    in_rs1_predetermined = s1p;
    in_rs1_sel           = s1;
    in_rs1_val           = s1v;
    in_rs2_valid         = 1'b1;
    in_rs2_predetermined = 1'b0;
    in_rs2_sel           = s2;
    in_rs2_val           = $urandom;
    in_rs3_valid         = 1'($urandom_range(0, 1));
    in_rs3_predetermined = 1'($urandom_range(0, 1));
    in_rs3_sel           = 5'($urandom);
    in_rs3_val           = $urandom;
  endtask

  // One clock cycle: score any output taken by dispatch, predict this edge, step, check.
  task automatic cyc();
    logic        rdn, adv, rdy, acc;
    logic [5:0]  prd;
    logic [5:0]  arch_n [32];
    logic [63:0] free_n, refs;
    exp_t        e;
    #1;
    if (clk_en && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_out", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check_eq("sb_pc",   64'(out_pc),   64'(e.pc));
        check_eq("sb_meta", 64'(out_meta), 64'(e.meta));
        check_eq("sb_rsv",  64'({out_rs3_valid, out_rs2_valid, out_rs1_valid}), 64'(e.v));
        check_eq("sb_rsp",  64'({out_rs3_predetermined, out_rs2_predetermined, out_rs1_predetermined}), 64'(e.p));
        check_eq("sb_p1",   64'(out_rs1_preg), 64'(e.p1));
        check_eq("sb_p2",   64'(out_rs2_preg), 64'(e.p2));
        check_eq("sb_p3",   64'(out_rs3_preg), 64'(e.p3));
        check_eq("sb_vals", 64'(out_rs1_val ^ out_rs2_val ^ {out_rs3_val[15:0], out_rs3_val[31:16]}),
                            64'(e.v1 ^ e.v2 ^ {e.v3[15:0], e.v3[31:16]}));
        check_eq("sb_v1",   64'(out_rs1_val), 64'(e.v1));
        check_eq("sb_rdv",  64'(out_rd_valid), 64'(e.rdv));
        check_eq("sb_prd",  64'(out_prd), 64'(e.prd));
        check_eq("sb_old",  64'(out_old_prd), 64'(e.old));
      end
    end
    rdn = in_rd_valid && (in_rd_sel != 5'd0);
    adv = !m_ov || out_ready;
    rdy = adv && !flush_valid && (!rdn || (m_free != 64'd0));
    check_eq("in_ready", 64'(in_ready), 64'(rdy));
    acc = in_valid && rdy && clk_en;
    prd = 6'd0;
    for (int p = 63; p >= 0; p--) begin
      if (m_free[p]) prd = 6'(p);
    end
    if (acc) begin
      e.pc   = in_pc;
      e.meta = in_meta;
      e.v    = {in_rs3_valid, in_rs2_valid, in_rs1_valid};
      e.p    = {in_rs3_predetermined, in_rs2_predetermined, in_rs1_predetermined};
      e.p1   = (in_rs1_valid && !in_rs1_predetermined) ? m_spec[in_rs1_sel] : 6'd0;
      e.p2   = (in_rs2_valid && !in_rs2_predetermined) ? m_spec[in_rs2_sel] : 6'd0;
      e.p3   = (in_rs3_valid && !in_rs3_predetermined) ? m_spec[in_rs3_sel] : 6'd0;
      e.v1   = in_rs1_val;
      e.v2   = in_rs2_val;
      e.v3   = in_rs3_val;
      e.rdv  = rdn;
      e.prd  = rdn ? prd : 6'd0;
      e.old  = rdn ? m_spec[in_rd_sel] : 6'd0;
      sb.push_back(e);
    end
`ifdef RENAME_PERF_CNT_EN
    if (clk_en && in_valid && adv && rdn && (m_free == 64'd0) && (m_perf != 32'hFFFF_FFFF))
      m_perf = m_perf + 32'd1;
`endif
    if (clk_en) begin
      arch_n = m_arch;
      free_n = m_free;
      if (commit_valid) begin
        arch_n[commit_arch_rd] = commit_prd;
        free_n[commit_old_prd] = 1'b1;
      end
      if (flush_valid) begin
        refs = 64'd0;
        for (int i = 0; i < 32; i++) refs[arch_n[i]] = 1'b1;
        m_free    = ~refs;
        m_free[0] = 1'b0;
        m_spec    = arch_n;
        m_ov      = 1'b0;
        sb.delete();
      end else begin
        if (acc && rdn) begin
          m_spec[in_rd_sel] = prd;
          free_n[prd]       = 1'b0;
        end
        m_free = free_n;
        m_ov   = acc || (m_ov && !adv);
      end
      m_arch = arch_n;
    end
    @(posedge clk);
    #1;
    check_eq("out_valid",  64'(out_valid),  64'(m_ov));
    check_eq("free_count", 64'(free_count), 64'($countones(m_free)));
`ifdef RENAME_PERF_CNT_EN
    check_eq("perf", 64'(perf_freelist_stall), 64'(m_perf));
`endif
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; flush_valid = 1'b0; out_ready = 1'b1;
    commit_valid = 1'b0; commit_arch_rd = 5'd0; commit_prd = 6'd0; commit_old_prd = 6'd0;
    pc_next = 32'h0000_1000;
    set_instr(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'd0, 5'd0);
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid",  64'(out_valid), 64'(0));
    check_eq("rst_free_count", 64'(free_count), 64'(32));
    check_eq("rst_out_prd",    64'(out_prd), 64'(0));
    check_eq("rst_out_pc",     64'(out_pc), 64'(0));
    rst = 1'b0;

    // add x5,x1,x2 then x6 = x5 + x5 back to back
    set_instr(1'b1, 1'b1, 5'd5, 5'd1, 1'b0, 32'd0, 5'd2);
    cyc();
    check_eq("t1_prd",  64'(out_prd), 64'(32));
    check_eq("t1_old",  64'(out_old_prd), 64'(5));
    check_eq("t1_rs1",  64'(out_rs1_preg), 64'(1));
    check_eq("t1_rs2",  64'(out_rs2_preg), 64'(2));
    check_eq("t1_fc",   64'(free_count), 64'(31));
    set_instr(1'b1, 1'b1, 5'd6, 5'd5, 1'b0, 32'd0, 5'd5);
    cyc();
    check_eq("t2_rs1",  64'(out_rs1_preg), 64'(32));
    check_eq("t2_rs2",  64'(out_rs2_preg), 64'(32));
    check_eq("t2_prd",  64'(out_prd), 64'(33));

    // rd = x0 with rs1 = x0 predetermined immediate
    t3_pc = pc_next;
    set_instr(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 32'h10, 5'd3);
    cyc();
    check_eq("t3_rdv",  64'(out_rd_valid), 64'(0));
    check_eq("t3_prd",  64'(out_prd), 64'(0));
    check_eq("t3_val",  64'(out_rs1_val), 64'(32'h10));
    check_eq("t3_rs1p", 64'(out_rs1_preg), 64'(0));
    check_eq("t3_fc",   64'(free_count), 64'(30));

    // clock enable low: nothing moves
    clk_en = 1'b0;
    set_instr(1'b1, 1'b1, 5'd8, 5'd1, 1'b0, 32'd0, 5'd2);
    cyc();
    check_eq("ce_pc", 64'(out_pc), 64'(t3_pc));
    clk_en = 1'b1;

    // dispatch backpressure for 3 cycles with a new instruction waiting
    out_ready = 1'b0;
    set_instr(1'b1, 1'b1, 5'd7, 5'd6, 1'b0, 32'd0, 5'd1);
    repeat (3) begin
      cyc();
      check_eq("bp_pc",    64'(out_pc), 64'(t3_pc));
      check_eq("bp_valid", 64'(out_valid), 64'(1));
      check_eq("bp_fc",    64'(free_count), 64'(30));
    end
    out_ready = 1'b1;
    cyc();
    check_eq("bp_rel_prd", 64'(out_prd), 64'(34));

    // drain the free list
    for (int k = 0; k < 64 && m_free != 64'd0; k++) begin
      set_instr(1'b1, 1'b1, 5'(10 + (k % 20)), 5'($urandom), 1'b0, 32'd0, 5'($urandom));
      cyc();
    end
    check_eq("empty_fc", 64'(free_count), 64'(0));

    // empty free list: rd stalls, no-rd passes, commit frees next cycle
`ifdef RENAME_PERF_CNT_EN
    perf0 = m_perf;
`endif
    set_instr(1'b1, 1'b1, 5'd7, 5'd1, 1'b0, 32'd0, 5'd2);
    repeat (3) begin
      #1;
      check_eq("st_ready", 64'(in_ready), 64'(0));
      cyc();
    end
`ifdef RENAME_PERF_CNT_EN
    check_eq("st_perf", 64'(perf_freelist_stall), 64'(perf0 + 32'd3));
`endif
    set_instr(1'b1, 1'b0, 5'd7, 5'd1, 1'b0, 32'd0, 5'd2);
    #1;
    check_eq("nord_ready", 64'(in_ready), 64'(1));
    cyc();
    set_instr(1'b1, 1'b1, 5'd7, 5'd1, 1'b0, 32'd0, 5'd2);
    commit_valid = 1'b1; commit_arch_rd = 5'd9; commit_prd = 6'd40; commit_old_prd = 6'd9;
    #1;
    check_eq("cm_ready", 64'(in_ready), 64'(0));
    cyc();
    commit_valid = 1'b0;
    cyc();
    check_eq("cm_prd", 64'(out_prd), 64'(9));
    check_eq("cm_rdv", 64'(out_rd_valid), 64'(1));
    in_valid = 1'b0;
    cyc();

    // asynchronous reset in the middle of a cycle
    set_instr(1'b1, 1'b1, 5'd12, 5'd1, 1'b0, 32'd0, 5'd2);
    #3;
    rst = 1'b1;
    #1;
    check_eq("mr_valid", 64'(out_valid), 64'(0));
    check_eq("mr_fc",    64'(free_count), 64'(32));
    check_eq("mr_prd",   64'(out_prd), 64'(0));
    reset_model();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // x3 -> 32, x3 -> 33, then commit of the first together with flush
    set_instr(1'b1, 1'b1, 5'd3, 5'd1, 1'b0, 32'd0, 5'd2);
    cyc();
    check_eq("f1_prd", 64'(out_prd), 64'(32));
    set_instr(1'b1, 1'b1, 5'd3, 5'd3, 1'b0, 32'd0, 5'd2);
    cyc();
    check_eq("f2_prd", 64'(out_prd), 64'(33));
    check_eq("f2_old", 64'(out_old_prd), 64'(32));
    in_valid = 1'b0;
    commit_valid = 1'b1; commit_arch_rd = 5'd3; commit_prd = 6'd32; commit_old_prd = 6'd3;
    flush_valid = 1'b1;
    cyc();
    commit_valid = 1'b0;
    flush_valid = 1'b0;
    check_eq("fl_valid", 64'(out_valid), 64'(0));
    check_eq("fl_fc",    64'(free_count), 64'(32));
    set_instr(1'b1, 1'b1, 5'd4, 5'd3, 1'b0, 32'd0, 5'd3);
    cyc();
    check_eq("fa_rs1", 64'(out_rs1_preg), 64'(32));
    check_eq("fa_prd", 64'(out_prd), 64'(3));
    set_instr(1'b1, 1'b1, 5'd5, 5'd4, 1'b0, 32'd0, 5'd1);
    cyc();
    check_eq("fb_prd", 64'(out_prd), 64'(33));
    check_eq("fb_rs1", 64'(out_rs1_preg), 64'(3));
    in_valid = 1'b0;
    cyc();
    cyc();
    check_eq("sb_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
